// File: rtl/mem_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_ctrl
// Purpose  : Sequences 8/16-bit CPU loads/stores into little-endian byte
//            accesses on a 64K x 8 synchronous single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic [7:0]        mem_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              word_q, word_d;
  logic [7:0]        rdata_lo_q, rdata_lo_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;

  assign req_ready = rst_n && (state_q == IDLE);

  // RAM port signals are computed for the state being entered, so they are
  // stable for the whole LO/HI cycle and sampled by the RAM at its end.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    word_d      = word_q;
    rdata_lo_d  = rdata_lo_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          we_d       = req_we;
          word_d     = req_word;
          mem_addr_d = req_addr;
          mem_data_d = req_wdata[7:0];
          mem_we_d   = req_we;
          state_d    = LO;
        end
      end
      LO: begin
        if (word_q) begin
          mem_addr_d = addr_q + ADDR_ONE;
          mem_data_d = wdata_q[15:8];
          mem_we_d   = we_q;
          state_d    = HI;
        end else begin
          state_d = FIN;
        end
      end
      HI: begin
        // Low byte is held internally so rsp_rdata only changes on completion.
        if (!we_q) begin
          rdata_lo_d = mem_q;
        end
        state_d = FIN;
      end
      FIN: begin
        if (!we_q) begin
          rdata_d = word_q ? {mem_q, rdata_lo_q} : {8'h00, mem_q};
        end
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      rdata_lo_q  <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      word_q      <= word_d;
      rdata_lo_q  <= rdata_lo_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_word_ctrl
// Purpose  : Directed self-checking bench for mem_word_ctrl with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_word_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_word;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic [7:0]  mem_q;

  logic        tb_wr;
  logic [15:0] tb_waddr;
  logic [7:0]  tb_wdat;
  logic [7:0]  ram [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_word_ctrl #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_word  (req_word),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_q     (mem_q)
  );

  // Synchronous RAM: write at the edge, read data valid the following cycle.
  always @(posedge clk) begin
    if (mem_we === 1'b1) ram[mem_addr] <= mem_data;
    else if (tb_wr) ram[tb_waddr] <= tb_wdat;
    mem_q <= ram[mem_addr];
  end

  typedef struct {
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];
  vec_t strm[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1;
    req_we    = v.we;
    req_word  = v.word;
    req_addr  = v.addr;
    req_wdata = v.wdata;
  endtask

  // Call at a negedge; returns at the negedge of the rsp_valid cycle.
  task automatic run_req(input vec_t v, output int lat, output logic [15:0] rd,
                         output int wecnt, output logic rdy);
    drive(v);
    #1;
    rdy = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat   = 0;
    wecnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (mem_we === 1'b1) wecnt++;
      if (rsp_valid === 1'b1) break;
    end
    rd = rsp_rdata;
  endtask

  initial begin
    int          lat, wecnt, idx, acc, rsp;
    logic [15:0] rd;
    logic        rdy, accepted, flag;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; tb_wr = 1'b0; tb_waddr = '0; tb_wdat = '0;

    vecs[0]  = '{1'b1, 1'b0, 16'h1234, 16'h00A5, 16'h0000, 3};
    vecs[1]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h00A5, 3};
    vecs[2]  = '{1'b1, 1'b1, 16'h2000, 16'hBEEF, 16'h00A5, 4};
    vecs[3]  = '{1'b0, 1'b1, 16'h2000, 16'h0000, 16'hBEEF, 4};
    vecs[4]  = '{1'b0, 1'b0, 16'h2001, 16'h0000, 16'h00BE, 3};
    vecs[5]  = '{1'b1, 1'b1, 16'hFFFF, 16'h1122, 16'h00BE, 4};
    vecs[6]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1122, 4};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0011, 3};
    vecs[8]  = '{1'b1, 1'b0, 16'h0050, 16'h77FF, 16'h0011, 3};
    vecs[9]  = '{1'b0, 1'b1, 16'h0050, 16'h0000, 16'h00FF, 4};
    vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0022, 3};

    strm[0] = '{1'b1, 1'b0, 16'h3000, 16'h0011, 16'h0000, 3};
    strm[1] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h0011, 3};
    strm[2] = '{1'b1, 1'b0, 16'h3001, 16'h0022, 16'h0000, 3};
    strm[3] = '{1'b0, 1'b0, 16'h3001, 16'h0000, 16'h0022, 3};
    strm[4] = '{1'b1, 1'b1, 16'h3002, 16'hABCD, 16'h0000, 4};
    strm[5] = '{1'b0, 1'b1, 16'h3002, 16'h0000, 16'hABCD, 4};

    // Reset, with RAM presets loaded through the side port meanwhile.
    @(posedge clk); #1;
    tb_wr = 1'b1; tb_waddr = 16'h0051; tb_wdat = 8'h00;
    @(posedge clk); #1;
    tb_waddr = 16'h0101; tb_wdat = 8'h5A;
    @(posedge clk); #1;
    tb_wr = 1'b0;
    @(negedge clk);
    chk("reset_ready",     req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rdata",     rsp_rdata, 0);
    chk("reset_mem_we",    mem_we,    0);
    chk("reset_mem_addr",  mem_addr,  0);
    chk("reset_mem_data",  mem_data,  0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_req(vecs[i], lat, rd, wecnt, rdy);
      chk($sformatf("vec%0d_ready", i),   rdy,   1);
      chk($sformatf("vec%0d_latency", i), lat,   vecs[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i),   rd,    vecs[i].exp_rd);
      chk($sformatf("vec%0d_we_cycles", i), wecnt,
          vecs[i].we ? (vecs[i].word ? 2 : 1) : 0);
    end
    chk("ram_2000", ram[16'h2000], 8'hEF);
    chk("ram_2001", ram[16'h2001], 8'hBE);
    chk("ram_ffff", ram[16'hFFFF], 8'h22);
    chk("ram_0000", ram[16'h0000], 8'h11);
    chk("ram_0050", ram[16'h0050], 8'hFF);

    // Streaming: req_valid held high, each new request taken on the rsp cycle.
    @(negedge clk);
    chk("idle_gap_rsp_valid", rsp_valid, 0);
    idx = 0; acc = 0; rsp = 0;
    drive(strm[0]);
    #1;
    for (int cyc = 0; cyc < 60 && rsp < 6; cyc++) begin
      if (rsp_valid === 1'b1) begin
        if (!strm[rsp].we) chk($sformatf("stream%0d_rdata", rsp), rsp_rdata, strm[rsp].exp_rd);
        rsp++;
      end
      accepted = req_valid && (req_ready === 1'b1);
      if (accepted) begin
        acc++;
        if (acc > 1) chk("stream_accept_on_rsp", rsp_valid, 1);
      end
      @(posedge clk); #1;
      if (accepted) begin
        idx++;
        if (idx < 6) drive(strm[idx]);
        else req_valid = 1'b0;
      end
      @(negedge clk); #1;
    end
    req_valid = 1'b0;
    chk("stream_accepts", acc, 6);
    chk("stream_rsps",    rsp, 6);

    // Reset asserted during LO of a word store: only the low byte lands.
    @(negedge clk);
    drive('{1'b1, 1'b1, 16'h0100, 16'h3344, 16'h0000, 4});
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_we",    mem_we,    0);
    chk("abort_mem_addr",  mem_addr,  0);
    chk("abort_mem_data",  mem_data,  0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rdata",     rsp_rdata, 0);
    chk("abort_ready",     req_ready, 1);
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_we !== 1'b0) flag = 1'b1;
    end
    chk("abort_no_rsp", flag, 0);
    chk("abort_ram_0100", ram[16'h0100], 8'h44);
    chk("abort_ram_0101", ram[16'h0101], 8'h5A);
    run_req('{1'b0, 1'b1, 16'h0100, 16'h0000, 16'h5A44, 4}, lat, rd, wecnt, rdy);
    chk("post_abort_ready",   rdy, 1);
    chk("post_abort_latency", lat, 4);
    chk("post_abort_rdata",   rd,  16'h5A44);

    // Reset held with a pending request: nothing may be accepted.
    @(negedge clk);
    rst_n = 1'b0;
    drive('{1'b1, 1'b0, 16'h0200, 16'h0099, 16'h0000, 3});
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || mem_we !== 1'b0) flag = 1'b1;
    end
    chk("rst_hold_ready_we", flag, 0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_we !== 1'b0) flag = 1'b1;
    end
    chk("rst_hold_nothing_accepted", flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
